// File: rtl/bp_be_pkg.sv
// Shared types for the BE pair scheduler: processor config, FE queue entry
// layout, scheduler states and the rv64 major opcodes used by the hazard check.
package bp_be_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    localparam int vaddr_width_gp               = 39;
    localparam int branch_metadata_fwd_width_gp = 36;
    localparam int instr_width_gp               = 32;
    localparam int fe_queue_width_gp            = 2 + vaddr_width_gp + instr_width_gp
                                                + branch_metadata_fwd_width_gp;

    typedef enum logic [1:0] {
        e_instr_fetch = 2'b00,
        e_exception   = 2'b01,
        e_icache_miss = 2'b10
    } bp_fe_queue_type_e;

    typedef struct packed {
        bp_fe_queue_type_e                       msg_type;
        logic [vaddr_width_gp-1:0]               pc;
        logic [instr_width_gp-1:0]               instr;
        logic [branch_metadata_fwd_width_gp-1:0] branch_metadata_fwd;
    } bp_fe_queue_s;

    typedef enum logic [0:0] {
        e_pair   = 1'b0,
        e_second = 1'b1
    } bp_be_pair_state_e;

    localparam logic [6:0] rv64_load_op_gp     = 7'b0000011;
    localparam logic [6:0] rv64_fload_op_gp    = 7'b0000111;
    localparam logic [6:0] rv64_misc_mem_op_gp = 7'b0001111;
    localparam logic [6:0] rv64_op_imm_op_gp   = 7'b0010011;
    localparam logic [6:0] rv64_auipc_op_gp    = 7'b0010111;
    localparam logic [6:0] rv64_op_imm32_op_gp = 7'b0011011;
    localparam logic [6:0] rv64_store_op_gp    = 7'b0100011;
    localparam logic [6:0] rv64_fstore_op_gp   = 7'b0100111;
    localparam logic [6:0] rv64_amo_op_gp      = 7'b0101111;
    localparam logic [6:0] rv64_op_op_gp       = 7'b0110011;
    localparam logic [6:0] rv64_lui_op_gp      = 7'b0110111;
    localparam logic [6:0] rv64_op32_op_gp     = 7'b0111011;
    localparam logic [6:0] rv64_fmadd_op_gp    = 7'b1000011;
    localparam logic [6:0] rv64_fmsub_op_gp    = 7'b1000111;
    localparam logic [6:0] rv64_fnmsub_op_gp   = 7'b1001011;
    localparam logic [6:0] rv64_fnmadd_op_gp   = 7'b1001111;
    localparam logic [6:0] rv64_fp_op_gp       = 7'b1010011;
    localparam logic [6:0] rv64_branch_op_gp   = 7'b1100011;
    localparam logic [6:0] rv64_jalr_op_gp     = 7'b1100111;
    localparam logic [6:0] rv64_jal_op_gp      = 7'b1101111;
    localparam logic [6:0] rv64_system_op_gp   = 7'b1110011;

    function automatic int fe_queue_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return fe_queue_width_gp;
            default:          return fe_queue_width_gp;
        endcase
    endfunction

endpackage

// File: rtl/bp_be_pair_hazard.sv
// Combinational pairing hazard: high when the two FE queue entries must not
// dispatch in the same cycle.
module bp_be_pair_hazard
    import bp_be_pkg::*;
(
    input  bp_fe_queue_s fe_queue1_i,
    input  bp_fe_queue_s fe_queue2_i,
    output logic         hazard_o
);

    logic [6:0] op1_s, op2_s;
    logic [4:0] rd1_s, rs1_2_s, rs2_2_s;
    logic       not_fetch_s, ctrl1_s, writes_rf1_s, reads_rs1_2_s, reads_rs2_2_s;
    logic       raw_s, both_mem_s, special1_s, special2_s;
    logic       unused_fields_s;

    function automatic logic is_mem(logic [6:0] op);
        return op inside {rv64_load_op_gp, rv64_store_op_gp, rv64_fload_op_gp,
                          rv64_fstore_op_gp, rv64_amo_op_gp};
    endfunction

    // FP compute ops cover FDIV/FSQRT; integer DIV/DIVU/REM/REMU are M-ext with funct3[2] set
    function automatic logic is_special(logic [31:0] instr);
        logic fp_s, long_s;
        fp_s   = instr[6:0] inside {rv64_fp_op_gp, rv64_fmadd_op_gp, rv64_fmsub_op_gp,
                                    rv64_fnmsub_op_gp, rv64_fnmadd_op_gp};
        long_s = (instr[6:0] inside {rv64_op_op_gp, rv64_op32_op_gp})
               & (instr[31:25] == 7'b0000001) & instr[14];
        return (instr[6:0] inside {rv64_system_op_gp, rv64_misc_mem_op_gp}) | fp_s | long_s;
    endfunction

    // Field decode and hazard terms
    always_comb begin
        op1_s   = fe_queue1_i.instr[6:0];
        op2_s   = fe_queue2_i.instr[6:0];
        rd1_s   = fe_queue1_i.instr[11:7];
        rs1_2_s = fe_queue2_i.instr[19:15];
        rs2_2_s = fe_queue2_i.instr[24:20];

        not_fetch_s   = (fe_queue1_i.msg_type != e_instr_fetch)
                      | (fe_queue2_i.msg_type != e_instr_fetch);
        ctrl1_s       = op1_s inside {rv64_branch_op_gp, rv64_jal_op_gp, rv64_jalr_op_gp};
        writes_rf1_s  = op1_s inside {rv64_lui_op_gp, rv64_auipc_op_gp, rv64_op_imm_op_gp,
                                      rv64_op_imm32_op_gp, rv64_op_op_gp, rv64_op32_op_gp,
                                      rv64_load_op_gp, rv64_amo_op_gp, rv64_jal_op_gp,
                                      rv64_jalr_op_gp};
        reads_rs1_2_s = op2_s inside {rv64_op_imm_op_gp, rv64_op_imm32_op_gp, rv64_op_op_gp,
                                      rv64_op32_op_gp, rv64_load_op_gp, rv64_store_op_gp,
                                      rv64_fload_op_gp, rv64_fstore_op_gp, rv64_amo_op_gp,
                                      rv64_branch_op_gp, rv64_jalr_op_gp, rv64_system_op_gp};
        reads_rs2_2_s = op2_s inside {rv64_op_op_gp, rv64_op32_op_gp, rv64_store_op_gp,
                                      rv64_amo_op_gp, rv64_branch_op_gp};

        raw_s = writes_rf1_s & (rd1_s != 5'd0)
              & ((reads_rs1_2_s & (rs1_2_s == rd1_s)) | (reads_rs2_2_s & (rs2_2_s == rd1_s)));
        both_mem_s = is_mem(op1_s) & is_mem(op2_s);
        special1_s = is_special(fe_queue1_i.instr);
        special2_s = is_special(fe_queue2_i.instr);

        hazard_o = not_fetch_s | ctrl1_s | raw_s | both_mem_s | special1_s | special2_s;
    end

    assign unused_fields_s = ^{fe_queue1_i.pc, fe_queue1_i.branch_metadata_fwd,
                               fe_queue2_i.pc, fe_queue2_i.branch_metadata_fwd};

endmodule

// File: rtl/bp_be_pair_scheduler.sv
// Pair scheduler between the BE issue queue and the dual dispatch ports.
// Optional saturating statistics counters are enabled by BP_BE_PAIR_STATS_EN.
module bp_be_pair_scheduler
    import bp_be_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
`ifdef BP_BE_PAIR_STATS_EN
    parameter int stat_width_p = 32,
`endif
    localparam int fe_queue_width_lp = fe_queue_width(bp_params_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic [fe_queue_width_lp-1:0] fe_queue1_i,
    input  logic [fe_queue_width_lp-1:0] fe_queue2_i,
    input  logic                         fe_queue_v_i,
    input  logic                         fe_queue_v2_i,
    output logic                         fe_queue_yumi_o,
    output logic [fe_queue_width_lp-1:0] dispatch1_o,
    output logic [fe_queue_width_lp-1:0] dispatch2_o,
    output logic                         dispatch_v1_o,
    output logic                         dispatch_v2_o,
    input  logic                         dispatch_ready_i,
    output logic                         split_o
`ifdef BP_BE_PAIR_STATS_EN
   ,output logic [stat_width_p-1:0]      pair_cnt_o,
    output logic [stat_width_p-1:0]      single_cnt_o,
    output logic [stat_width_p-1:0]      split_cnt_o
`endif
);

    bp_be_pair_state_e              state_q, state_d;
    logic [fe_queue_width_lp-1:0]   held_q, held_d;
    logic                           hazard_s;

    bp_be_pair_hazard hazard_u (
        .fe_queue1_i (bp_fe_queue_s'(fe_queue1_i)),
        .fe_queue2_i (bp_fe_queue_s'(fe_queue2_i)),
        .hazard_o    (hazard_s)
    );

    // Next state, held slot 2 and dispatch outputs; reset and flush kill all valids
    always_comb begin
        state_d         = state_q;
        held_d          = held_q;
        dispatch1_o     = '0;
        dispatch2_o     = '0;
        dispatch_v1_o   = 1'b0;
        dispatch_v2_o   = 1'b0;
        fe_queue_yumi_o = 1'b0;
        split_o         = 1'b0;
        if (reset_i | flush_i) begin
            state_d = e_pair;
            held_d  = '0;
        end else begin
            case (state_q)
                e_pair: begin
                    if (fe_queue_v_i) begin
                        dispatch1_o   = fe_queue1_i;
                        dispatch2_o   = fe_queue2_i;
                        dispatch_v1_o = 1'b1;
                        dispatch_v2_o = fe_queue_v2_i & ~hazard_s;
                        split_o       = fe_queue_v2_i & hazard_s;
                        if (dispatch_ready_i) begin
                            fe_queue_yumi_o = 1'b1;
                            if (fe_queue_v2_i & hazard_s) begin
                                held_d  = fe_queue2_i;
                                state_d = e_second;
                            end else begin
                                state_d = e_pair;
                            end
                        end else begin
                            state_d = e_pair;
                        end
                    end else begin
                        state_d = e_pair;
                    end
                end
                e_second: begin
                    dispatch1_o   = held_q;
                    dispatch_v1_o = 1'b1;
                    if (dispatch_ready_i) begin
                        state_d = e_pair;
                        held_d  = '0;
                    end else begin
                        state_d = e_second;
                    end
                end
                default: begin
                    state_d = e_pair;
                    held_d  = '0;
                end
            endcase
        end
    end

    // State and held-entry registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_pair;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

`ifdef BP_BE_PAIR_STATS_EN
    logic [stat_width_p-1:0] pair_cnt_q, pair_cnt_d;
    logic [stat_width_p-1:0] single_cnt_q, single_cnt_d;
    logic [stat_width_p-1:0] split_cnt_q, split_cnt_d;
    logic                    pair_inc_s, single_inc_s, split_inc_s;

    // Saturating event counters
    always_comb begin
        pair_inc_s   = dispatch_v1_o & dispatch_v2_o & dispatch_ready_i;
        single_inc_s = dispatch_v1_o & ~dispatch_v2_o & dispatch_ready_i;
        split_inc_s  = (state_q == e_pair) & (state_d == e_second);
        pair_cnt_d   = (pair_inc_s & ~(&pair_cnt_q))
                     ? pair_cnt_q + stat_width_p'(1) : pair_cnt_q;
        single_cnt_d = (single_inc_s & ~(&single_cnt_q))
                     ? single_cnt_q + stat_width_p'(1) : single_cnt_q;
        split_cnt_d  = (split_inc_s & ~(&split_cnt_q))
                     ? split_cnt_q + stat_width_p'(1) : split_cnt_q;
    end

    // Counter registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pair_cnt_q   <= '0;
            single_cnt_q <= '0;
            split_cnt_q  <= '0;
        end else begin
            pair_cnt_q   <= pair_cnt_d;
            single_cnt_q <= single_cnt_d;
            split_cnt_q  <= split_cnt_d;
        end
    end

    assign pair_cnt_o   = pair_cnt_q;
    assign single_cnt_o = single_cnt_q;
    assign split_cnt_o  = split_cnt_q;
`endif

endmodule

// File: tb/tb_bp_be_pair_scheduler.sv
// Directed, table-driven bench for bp_be_pair_scheduler plus hand sequences for
// split, stall and flush behaviour.
module tb_bp_be_pair_scheduler;
    import bp_be_pkg::*;

    localparam int W = fe_queue_width_gp;

    logic         clk = 1'b0;
    logic         reset_i, flush_i, fe_queue_v_i, fe_queue_v2_i, dispatch_ready_i;
    logic [W-1:0] fe_queue1_i, fe_queue2_i, dispatch1_o, dispatch2_o;
    logic         fe_queue_yumi_o, dispatch_v1_o, dispatch_v2_o, split_o;
`ifdef BP_BE_PAIR_STATS_EN
    logic [31:0]  pair_cnt, single_cnt, split_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bp_be_pair_scheduler dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .flush_i          (flush_i),
        .fe_queue1_i      (fe_queue1_i),
        .fe_queue2_i      (fe_queue2_i),
        .fe_queue_v_i     (fe_queue_v_i),
        .fe_queue_v2_i    (fe_queue_v2_i),
        .fe_queue_yumi_o  (fe_queue_yumi_o),
        .dispatch1_o      (dispatch1_o),
        .dispatch2_o      (dispatch2_o),
        .dispatch_v1_o    (dispatch_v1_o),
        .dispatch_v2_o    (dispatch_v2_o),
        .dispatch_ready_i (dispatch_ready_i),
        .split_o          (split_o)
`ifdef BP_BE_PAIR_STATS_EN
       ,.pair_cnt_o       (pair_cnt),
        .single_cnt_o     (single_cnt),
        .split_cnt_o      (split_cnt)
`endif
    );

    typedef struct {
        logic [W-1:0] fe1, fe2;
        logic         v, v2, rdy, fl;
        logic         e_v1, e_v2, e_yumi, e_split;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] enc_i(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                          logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(logic [6:0] op, logic [6:0] f7, logic [2:0] f3,
                                          logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(logic [6:0] op, logic [2:0] f3, logic [4:0] rs1,
                                          logic [4:0] rs2, logic [11:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    function automatic logic [W-1:0] mk(logic [1:0] msg, logic [38:0] pc, logic [31:0] instr);
        return {msg, pc, instr, 36'h0_1234_5678};
    endfunction

    function automatic vec_t vrec(logic [W-1:0] fe1, logic [W-1:0] fe2, logic v, logic v2,
                                  logic rdy, logic fl, logic e_v1, logic e_v2, logic e_yumi,
                                  logic e_split);
        vec_t r;
        r.fe1 = fe1; r.fe2 = fe2; r.v = v; r.v2 = v2; r.rdy = rdy; r.fl = fl;
        r.e_v1 = e_v1; r.e_v2 = e_v2; r.e_yumi = e_yumi; r.e_split = e_split;
        return r;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_ctl(string name, logic v1, logic v2, logic yumi, logic split);
        chk({name, ".v1"},    128'(dispatch_v1_o),   128'(v1));
        chk({name, ".v2"},    128'(dispatch_v2_o),   128'(v2));
        chk({name, ".yumi"},  128'(fe_queue_yumi_o), 128'(yumi));
        chk({name, ".split"}, 128'(split_o),         128'(split));
    endtask

    task automatic drive(logic [W-1:0] fe1, logic [W-1:0] fe2, logic v, logic v2,
                         logic rdy, logic fl);
        fe_queue1_i = fe1; fe_queue2_i = fe2; fe_queue_v_i = v; fe_queue_v2_i = v2;
        dispatch_ready_i = rdy; flush_i = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] addi_x1, addi_x2, addi_x0, add_x7, addi_x5, add_x6, add_x6b, beq, addi_x9;
    logic [W-1:0] div_x10, mul_x10, addi_x3, add_x3, sub_x4, addi_x8, addi_x9_imm8, fadd;
    logic [W-1:0] exc_addi, ld_x3, sd_x4, fence, add_x6_x1;

    initial begin
        addi_x1      = mk(2'b00, 39'h100, enc_i(7'b0010011, 5'd1, 5'd0, 12'd1));
        addi_x2      = mk(2'b00, 39'h104, enc_i(7'b0010011, 5'd2, 5'd0, 12'd2));
        addi_x0      = mk(2'b00, 39'h108, enc_i(7'b0010011, 5'd0, 5'd0, 12'd0));
        add_x7       = mk(2'b00, 39'h10c, enc_r(7'b0110011, 7'd0, 3'd0, 5'd7, 5'd0, 5'd0));
        addi_x5      = mk(2'b00, 39'h110, enc_i(7'b0010011, 5'd5, 5'd0, 12'd1));
        add_x6       = mk(2'b00, 39'h114, enc_r(7'b0110011, 7'd0, 3'd0, 5'd6, 5'd5, 5'd5));
        add_x6b      = mk(2'b00, 39'h118, enc_r(7'b0110011, 7'd0, 3'd0, 5'd6, 5'd1, 5'd5));
        beq          = mk(2'b00, 39'h11c, enc_s(7'b1100011, 3'd0, 5'd1, 5'd2, 12'd8));
        addi_x9      = mk(2'b00, 39'h120, enc_i(7'b0010011, 5'd9, 5'd0, 12'd3));
        addi_x3      = mk(2'b00, 39'h124, enc_i(7'b0010011, 5'd3, 5'd0, 12'd4));
        div_x10      = mk(2'b00, 39'h128, enc_r(7'b0110011, 7'd1, 3'd4, 5'd10, 5'd1, 5'd2));
        mul_x10      = mk(2'b00, 39'h12c, enc_r(7'b0110011, 7'd1, 3'd0, 5'd10, 5'd1, 5'd2));
        add_x3       = mk(2'b00, 39'h130, enc_r(7'b0110011, 7'd0, 3'd0, 5'd3, 5'd1, 5'd2));
        sub_x4       = mk(2'b00, 39'h134, enc_r(7'b0110011, 7'h20, 3'd0, 5'd4, 5'd5, 5'd6));
        addi_x8      = mk(2'b00, 39'h138, enc_i(7'b0010011, 5'd8, 5'd0, 12'd1));
        addi_x9_imm8 = mk(2'b00, 39'h13c, enc_i(7'b0010011, 5'd9, 5'd1, 12'd8));
        fadd         = mk(2'b00, 39'h140, enc_r(7'b1010011, 7'd0, 3'd0, 5'd1, 5'd2, 5'd3));
        exc_addi     = mk(2'b01, 39'h144, enc_i(7'b0010011, 5'd9, 5'd0, 12'd3));
        ld_x3        = mk(2'b00, 39'h148, enc_i(7'b0000011, 5'd3, 5'd1, 12'd0));
        sd_x4        = mk(2'b00, 39'h14c, enc_s(7'b0100011, 3'd3, 5'd2, 5'd4, 12'd0));
        fence        = mk(2'b00, 39'h150, enc_i(7'b0001111, 5'd0, 5'd0, 12'd0));
        add_x6_x1    = mk(2'b00, 39'h154, enc_r(7'b0110011, 7'd0, 3'd0, 5'd6, 5'd1, 5'd1));

        //                fe1      fe2           v     v2    rdy   fl    ev1   ev2   eyumi esplit
        vecs.push_back(vrec(addi_x1, addi_x2,      1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        vecs.push_back(vrec(addi_x0, add_x7,       1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        vecs.push_back(vrec(addi_x5, add_x6,       1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        vecs.push_back(vrec(addi_x5, add_x6b,      1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        vecs.push_back(vrec(beq,     addi_x9,      1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        vecs.push_back(vrec(addi_x3, div_x10,      1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        vecs.push_back(vrec(addi_x3, mul_x10,      1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        vecs.push_back(vrec(add_x3,  sub_x4,       1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        vecs.push_back(vrec(addi_x8, addi_x9_imm8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        vecs.push_back(vrec(fadd,    addi_x9,      1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        vecs.push_back(vrec(addi_x3, exc_addi,     1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        vecs.push_back(vrec(ld_x3,   sd_x4,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        vecs.push_back(vrec(ld_x3,   addi_x9_imm8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        vecs.push_back(vrec(addi_x3, fence,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        vecs.push_back(vrec(addi_x1, add_x6_x1,    1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        vecs.push_back(vrec(addi_x1, addi_x2,      1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(vrec(addi_x1, addi_x2,      1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(vrec(addi_x1, addi_x2,      1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));

        // Reset with a valid pair presented: everything stays quiet
        reset_i = 1'b1;
        drive(addi_x1, addi_x2, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        reset_i = 1'b0;
        drive(addi_x1, addi_x2, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_ctl("idle", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef BP_BE_PAIR_STATS_EN
        chk("single_cnt_rst", 128'(single_cnt), 128'd0);
        chk("pair_cnt_rst",   128'(pair_cnt),   128'd0);
        step();
        drive(addi_x1, addi_x2, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        drive(addi_x1, addi_x2, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("single_cnt_1", 128'(single_cnt), 128'd1);
        chk("pair_cnt_0",   128'(pair_cnt),   128'd0);
        chk("split_cnt_0",  128'(split_cnt),  128'd0);
`endif
        step();

        foreach (vecs[i]) begin
            drive(vecs[i].fe1, vecs[i].fe2, vecs[i].v, vecs[i].v2, vecs[i].rdy, vecs[i].fl);
            @(negedge clk);
            chk_ctl($sformatf("vec%0d", i), vecs[i].e_v1, vecs[i].e_v2, vecs[i].e_yumi,
                    vecs[i].e_split);
            if (vecs[i].e_v1) chk($sformatf("vec%0d.d1", i), 128'(dispatch1_o), 128'(vecs[i].fe1));
            if (vecs[i].e_v2) chk($sformatf("vec%0d.d2", i), 128'(dispatch2_o), 128'(vecs[i].fe2));
            step();
        end

        // RAW split with ready: slot 1 now, held ADD next cycle, then back to pairing
        drive(addi_x5, add_x6, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_ctl("raw0", 1'b1, 1'b0, 1'b1, 1'b1);
        chk("raw0.d1", 128'(dispatch1_o), 128'(addi_x5));
        step();
        drive(addi_x1, addi_x2, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_ctl("raw1", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("raw1.d1", 128'(dispatch1_o), 128'(add_x6));
        step();
        @(negedge clk);
        chk_ctl("raw2", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("raw2.d1", 128'(dispatch1_o), 128'(addi_x1));
        step();

        // LD/SD with a 3-cycle stall, then SD alone with its own 1-cycle stall
        drive(ld_x3, sd_x4, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_ctl($sformatf("stall%0d", c), 1'b1, 1'b0, 1'b0, 1'b1);
            chk($sformatf("stall%0d.d1", c), 128'(dispatch1_o), 128'(ld_x3));
            step();
        end
        dispatch_ready_i = 1'b1;
        @(negedge clk);
        chk_ctl("ldsd_go", 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        drive(addi_x1, addi_x2, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_ctl("sd_stall", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sd_stall.d1", 128'(dispatch1_o), 128'(sd_x4));
        step();
        dispatch_ready_i = 1'b1;
        @(negedge clk);
        chk_ctl("sd_go", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sd_go.d1", 128'(dispatch1_o), 128'(sd_x4));
        step();
        @(negedge clk);
        chk_ctl("after_sd", 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // Flush in e_second drops the held entry
        drive(addi_x5, add_x6, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        drive(addi_x1, addi_x2, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk_ctl("flush2", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        flush_i = 1'b0;
        @(negedge clk);
        chk_ctl("post_flush", 1'b0, 1'b0, 1'b0, 1'b0);
        fe_queue_v_i = 1'b1;
        fe_queue_v2_i = 1'b1;
        @(negedge clk);
        chk_ctl("post_flush_pair", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("post_flush_pair.d1", 128'(dispatch1_o), 128'(addi_x1));
        step();
        fe_queue_v_i = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_be_pair_scheduler.md
Name: bp_be_pair_scheduler

Overview:
- Sits directly downstream of the BE issue queue and consumes its paired FE queue output (slot 1, slot 2, one valid, one yumi).
- Each cycle it decides whether the pair can dispatch together, or must be split into two single dispatches.
- When a pair is split, it dispatches slot 1 first and dequeues the pair from the issue queue. It then holds slot 2 in a local register and dispatches it on a later cycle.
- Its outputs drive the dual dispatch ports of the calculator/scheduler.

Parameters:
- bp_params_p, e_bp_default_cfg, processor configuration; supplies vaddr_width_p, branch_metadata_fwd_width_p and fe_queue_width_lp.
- stat_width_p, 32, width of each statistics counter; only used when BP_BE_PAIR_STATS_EN is defined.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- flush_i  in  1  director/commit flush; discards the held slot 2.
- fe_queue1_i  in  fe_queue_width_lp  oldest entry of the pair.
- fe_queue2_i  in  fe_queue_width_lp  younger entry of the pair.
- fe_queue_v_i  in  1  pair valid.
- fe_queue_v2_i  in  1  slot 2 holds a real entry; low for odd-length fetch groups.
- fe_queue_yumi_o  out  1  pair consumed this cycle.
- dispatch1_o  out  fe_queue_width_lp  first dispatch lane.
- dispatch2_o  out  fe_queue_width_lp  second dispatch lane.
- dispatch_v1_o  out  1  lane 1 valid.
- dispatch_v2_o  out  1  lane 2 valid.
- dispatch_ready_i  in  1  downstream accepts both lanes this cycle.
- split_o  out  1  the current pair is being split (debug/perf).

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values: state e_pair, held register cleared, all outputs 0.
- States:
  - e_pair: presenting the pair from the issue queue.
  - e_second: presenting the held slot 2 alone.
- Pairing hazard (combinational on fe_queue1_i/fe_queue2_i). Split when any of the following holds:
  - either entry's msg_type is not e_instr_fetch;
  - slot 1 opcode is BRANCH, JAL or JALR;
  - slot 2 reads rs1 or rs2 equal to slot 1 rd, with rd != 0, and slot 1 writes the integer RF;
  - both entries are mem (LOAD/STORE/FLOAD/FSTORE/AMO);
  - either entry is SYSTEM, FENCE, long (DIV/REM/FDIV/FSQRT) or FP.
- Instruction fields:
  - opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
  - rs2 is only compared for opcodes that read it.
- In e_pair with fe_queue_v_i = 1:
  - dispatch1_o = fe_queue1_i and dispatch_v1_o = 1.
  - dispatch_v2_o = fe_queue_v2_i & ~hazard, with dispatch2_o = fe_queue2_i.
  - On dispatch_ready_i: fe_queue_yumi_o = 1.
  - If fe_queue_v2_i & hazard: latch fe_queue2_i and go to e_second. Otherwise stay in e_pair.
- In e_second:
  - dispatch1_o = held entry, dispatch_v1_o = 1, dispatch_v2_o = 0, fe_queue_yumi_o = 0.
  - On dispatch_ready_i: return to e_pair.
- Latency: dispatch outputs are combinational from the inputs in e_pair. The held entry appears the cycle after the split.
- Handshake: valid lanes stay stable until dispatch_ready_i. The yumi pulse is exactly one cycle per pair.
- Outputs with fe_queue_v_i = 0 in e_pair: dispatch_v1_o = 0, dispatch_v2_o = 0, fe_queue_yumi_o = 0.
- flush_i:
  - Forces e_pair next cycle and clears the held entry.
  - In the flush cycle, dispatch_v1_o, dispatch_v2_o and fe_queue_yumi_o are 0.
  - flush_i has priority over dispatch_ready_i.
- split_o = 1 in e_pair when fe_queue_v_i & fe_queue_v2_i & hazard; otherwise 0.
- A flush or reset arriving in e_second always drops the held entry.

Optional Feature:
- Macro: BP_BE_PAIR_STATS_EN.
- When defined:
  - Adds outputs pair_cnt_o, single_cnt_o, split_cnt_o, each stat_width_p bits, reset to 0.
  - pair_cnt_o increments on each accepted dual dispatch.
  - single_cnt_o increments on each accepted single dispatch.
  - split_cnt_o increments on each transition into e_second.
  - Counters saturate at all-ones.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- The state enum bp_be_pair_state_e {e_pair, e_second} belongs in bp_be_pkg.
- The hazard predicate goes in sub-module bp_be_pair_hazard: purely combinational, takes the two fe_queue entries and produces hazard_o.
- Opcode constants are reused from the existing rv64 defines.

Test Plan:
- ADDI x1; ADDI x2 (no hazard), ready = 1: both lanes valid, yumi = 1, state stays e_pair.
- ADDI x5,x0,1; ADD x6,x5,x5: lane 1 only, yumi = 1. Next cycle the held ADD is on lane 1 with dispatch_v2_o = 0, then the block returns to e_pair.
- LD x3; SD x4 (both mem), with ready held low 3 cycles then high: lane 1 stays stable through the stall, then yumi, then the SD dispatches alone.
- ADDI x0,x0,0 (rd = x0); ADD x7,x0,x0: no hazard, dual dispatch.
- Split, then flush_i in e_second: dispatch_v1_o = 0 in the flush cycle; the held entry is dropped and never dispatched; the block returns to e_pair.
- fe_queue_v2_i = 0 with one valid ADDI: single dispatch, yumi = 1, no e_second. With BP_BE_PAIR_STATS_EN defined, single_cnt_o goes 0 to 1.
